// File: rtl/mem_read_checker.sv
// mem_read_checker: sweeps a byte-wide memory port, rebuilds 16-bit words and checks them against PATTERN_BASE + addr
module mem_read_checker #(
  parameter logic [7:0]  ADDR_FIRST   = 8'h00,
  parameter logic [7:0]  ADDR_LAST    = 8'hFF,
  parameter logic [15:0] PATTERN_BASE = 16'h550A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  addr,
  output logic        cs,
  output logic        byte_sel,
  input  logic [7:0]  data_byte,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_count,
  output logic [7:0]  first_err_addr,
  output logic [15:0] first_err_data
);
  typedef enum logic [2:0] {IDLE, ADDR, LO, HI, CMP} state_t;
  state_t state_q, state_d;
  logic [7:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d, fea_q, fea_d;
  logic [15:0] fed_q, fed_d;
  logic [8:0] err_q, err_d;
  logic cs_q, cs_d, bs_q, bs_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic mismatch, running;
  assign running = state_q != IDLE;
  assign mismatch = {hi_q, lo_q} != PATTERN_BASE + {8'h00, addr_q};
  // state and output registers; reset outranks abort and start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= ADDR_FIRST;
      cs_q    <= 1'b0;
      bs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      bs_q    <= bs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
  // next state: abort wins over every step of a running sweep, including completion
  always_comb begin
    state_d = state_q;
    if (running && abort) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = start ? ADDR : IDLE;
        ADDR:    state_d = LO;
        LO:      state_d = HI;
        HI:      state_d = CMP;
        CMP:     state_d = (addr_q == ADDR_LAST) ? IDLE : ADDR;
        default: state_d = IDLE;
      endcase
  end
  // registered outputs and datapath; memory controls follow the state being entered
  always_comb begin
    addr_d = addr_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    fea_d  = fea_q;
    fed_d  = fed_q;
    cs_d   = state_d inside {ADDR, LO, HI};
    bs_d   = state_d == HI;
    lo_d   = (state_q == LO) ? data_byte : lo_q;
    hi_d   = (state_q == HI) ? data_byte : hi_q;
    if (!running && start) begin
      addr_d = ADDR_FIRST;
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      err_d  = '0;
      fea_d  = '0;
      fed_d  = '0;
    end else if (running && abort) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (state_q == CMP) begin
      err_d = mismatch ? err_q + 9'd1 : err_q;
      fea_d = (mismatch && err_q == '0) ? addr_q : fea_q;
      fed_d = (mismatch && err_q == '0) ? {hi_q, lo_q} : fed_q;
      if (addr_q == ADDR_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = err_d == '0;
      end else addr_d = addr_q + 8'd1;
    end
  end
  assign addr           = addr_q;
  assign cs             = cs_q;
  assign byte_sel       = bs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;
endmodule

// File: tb/tb_mem_read_checker.sv
// tb_mem_read_checker: directed sweeps against a registered 256x16 memory model with a result scoreboard
module tb_mem_read_checker;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, start2 = 1'b0;
  logic [7:0] addr, data_byte, fea, addr2, data_byte2, fea2;
  logic cs, byte_sel, busy, done, pass, cs2, byte_sel2, busy2, done2, pass2;
  logic [8:0] err_count, err_count2;
  logic [15:0] fed, fed2;
  logic [15:0] mem [256];
  logic swap = 1'b0;
  logic [15:0] word_q = '0, word2_q = '0;
  int checks = 0, passed = 0, edges;
  typedef struct packed {logic p; logic [8:0] e; logic [7:0] fa; logic [15:0] fd;} exp_t;
  exp_t sb [$];
  exp_t ex;
  always #5 clk = ~clk;
  mem_read_checker dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .addr(addr), .cs(cs),
    .byte_sel(byte_sel), .data_byte(data_byte), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(fea), .first_err_data(fed)
  );
  mem_read_checker #(.ADDR_FIRST(8'h05), .ADDR_LAST(8'h05)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .addr(addr2), .cs(cs2),
    .byte_sel(byte_sel2), .data_byte(data_byte2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_err_addr(fea2), .first_err_data(fed2)
  );
  // memory registers the word on a selected edge; the byte lane is picked combinationally
  always @(posedge clk) begin
    if (cs) word_q <= mem[addr];
    if (cs2) word2_q <= mem[addr2];
  end
  assign data_byte  = (byte_sel ^ swap) ? word_q[15:8] : word_q[7:0];
  assign data_byte2 = byte_sel2 ? word2_q[15:8] : word2_q[7:0];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic load(input int mode);
    for (int i = 0; i < 256; i++) mem[i] = 16'h550A + 16'(i);
    if (mode == 1) begin
      mem[8'h10] = 16'h0000;
      mem[8'h20] = 16'h5500;
    end
    swap = mode == 2;
  endtask
  task automatic push_exp(input int lo, input int hi);
    exp_t e;
    logic [15:0] w;
    e = '0;
    for (int a = lo; a <= hi; a++) begin
      w = swap ? {mem[a][7:0], mem[a][15:8]} : mem[a];
      if (w != 16'h550A + 16'(a)) begin
        if (e.e == 0) begin
          e.fa = 8'(a);
          e.fd = w;
        end
        e.e++;
      end
    end
    e.p = e.e == 0;
    sb.push_back(e);
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int maxc, output int n);
    exp_t e;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    e = sb.pop_front();
    chk({tag, "_result"}, {pass, err_count, fea, fed}, e);
  endtask
  initial begin
    load(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", {addr, cs, byte_sel, busy, done, pass, err_count, fea, fed}, 0);
    chk("reset_dut2", {addr2, cs2, busy2, done2}, {8'h05, 3'b000});
    // full correct sweep with per-cycle bus sequence
    push_exp(0, 255);
    pulse_start();
    for (int n = 0; n < 1024; n++) begin
      chk($sformatf("seq_n%0d", n), {busy, done, cs, byte_sel, addr},
          {1'b1, 1'b0, n % 4 != 3, n % 4 == 2, 8'(n / 4)});
      @(negedge clk);
    end
    wait_done("sweep_ok", 0, edges);
    // injected word faults; restart from done
    load(1);
    push_exp(0, 255);
    pulse_start();
    chk("restart_clears_done", {busy, done, pass, err_count}, {3'b100, 9'd0});
    wait_done("word_faults", 1100, edges);
    // swapped byte lanes
    load(2);
    push_exp(0, 255);
    pulse_start();
    wait_done("lane_swap", 1100, edges);
    // single-word range
    load(0);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("single_n%0d", n), {busy2, done2, cs2, addr2}, {1'b1, 1'b0, n != 3, 8'h05});
      @(negedge clk);
    end
    chk("single_result", {busy2, done2, pass2, err_count2}, {3'b011, 9'd0});
    // abort in HI of word 0x40, partial errors retained
    load(1);
    pulse_start();
    repeat (258) @(negedge clk);
    chk("abort_at_hi", {cs, byte_sel, addr}, {2'b11, 8'h40});
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", {busy, done, cs}, 0);
    chk("abort_partial", {err_count, fea, fed}, {9'd2, 8'h10, 16'h0000});
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_in_idle", {busy, done, cs, err_count}, {3'b000, 9'd2});
    push_exp(0, 255);
    pulse_start();
    chk("abort_restart", {busy, cs, addr, err_count}, {2'b11, 8'h00, 9'd0});
    wait_done("after_abort", 1100, edges);
    // reset mid-sweep
    pulse_start();
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("midsweep_reset", {addr, cs, byte_sel, busy, done, pass, err_count, fea, fed}, 0);
    // start while busy is ignored
    load(0);
    push_exp(0, 255);
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_start_ignored", {busy, cs, byte_sel, addr}, {3'b111, 8'h02});
    wait_done("busy_start", 1100, edges);
    chk("busy_start_timing", edges, 1014);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
